// File: rtl/dp_mem_responder_pkg.sv
// Shared types and constants for the datapath memory responder.
// word_t is the common 32-bit bus type for addresses and data.
package dp_mem_responder_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        IDLE,
        DACC,
        IACC,
        RESP
    } mem_resp_state_t;

    localparam word_t ERR_WORD_DEFAULT = 32'hBAD1BAD1;

endpackage

// File: rtl/dp_mem_responder_if.sv
// Datapath request/response and RAM strobe bundle for dp_mem_responder.
// slave = responder view, master = datapath plus RAM model view.
interface dp_mem_responder_if;
    import dp_mem_responder_pkg::*;

    logic  imemREN;
    word_t imemaddr;
    logic  dmemREN;
    logic  dmemWEN;
    word_t dmemaddr;
    word_t dmemstore;
    logic  halt;
    logic  ihit;
    word_t imemload;
    logic  dhit;
    word_t dmemload;
    logic  ramREN;
    logic  ramWEN;
    word_t ramaddr;
    word_t ramstore;
    word_t ramload;
    logic  ramready;
    logic  err;

    modport slave (
        input  imemREN, imemaddr, dmemREN, dmemWEN, dmemaddr, dmemstore, halt,
        input  ramload, ramready,
        output ihit, imemload, dhit, dmemload,
        output ramREN, ramWEN, ramaddr, ramstore, err
    );

    modport master (
        output imemREN, imemaddr, dmemREN, dmemWEN, dmemaddr, dmemstore, halt,
        output ramload, ramready,
        input  ihit, imemload, dhit, dmemload,
        input  ramREN, ramWEN, ramaddr, ramstore, err
    );

endinterface

// File: rtl/dp_mem_responder_wait.sv
// Access wait counter: cleared outside RAM accesses, counts each strobe cycle.
// tc is high while the count equals TIMEOUT-1 (the last cycle an access may wait).
module dp_mem_wait_counter #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic CLK,
    input  logic nRST,
    input  logic clr,
    input  logic en,
    output logic tc
);
    logic [15:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc = (cnt_q == 16'(TIMEOUT - 1));

endmodule

// File: rtl/dp_mem_responder.sv
// Arbitrates datapath fetch and load/store requests onto one RAM port, data first.
// Hit pulses one cycle after ramready (or timeout); requests are ignored outside IDLE.
// DP_MEM_IBUF_EN adds a one-entry fetch buffer that answers repeat fetches without RAM.
module dp_mem_responder
    import dp_mem_responder_pkg::*;
#(
    parameter int unsigned TIMEOUT  = 255,
    parameter word_t       ERR_WORD = ERR_WORD_DEFAULT
) (
    input logic               CLK,
    input logic               nRST,
    dp_mem_responder_if.slave bus
);
    mem_resp_state_t state_q, state_d;
    word_t addr_q, addr_d;
    word_t store_q, store_d;
    logic  wr_q, wr_d;
    logic  isd_q, isd_d;
    word_t imemload_q, imemload_d;
    word_t dmemload_q, dmemload_d;
    logic  err_q, err_d;
    logic  in_acc;
    logic  tc;
`ifdef DP_MEM_IBUF_EN
    logic  ib_vld_q, ib_vld_d;
    word_t ib_tag_q, ib_tag_d;
    word_t ib_word_q, ib_word_d;
`endif

    assign in_acc = (state_q == DACC) || (state_q == IACC);

    dp_mem_wait_counter #(.TIMEOUT(TIMEOUT)) u_wait (
        .CLK  (CLK),
        .nRST (nRST),
        .clr  (!in_acc),
        .en   (in_acc),
        .tc   (tc)
    );

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        store_d    = store_q;
        wr_d       = wr_q;
        isd_d      = isd_q;
        imemload_d = imemload_q;
        dmemload_d = dmemload_q;
        err_d      = err_q;
`ifdef DP_MEM_IBUF_EN
        ib_vld_d   = ib_vld_q;
        ib_tag_d   = ib_tag_q;
        ib_word_d  = ib_word_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.dmemREN || bus.dmemWEN) begin
                    addr_d  = bus.dmemaddr;
                    store_d = bus.dmemstore;
                    wr_d    = bus.dmemWEN;
                    isd_d   = 1'b1;
                    state_d = DACC;
`ifdef DP_MEM_IBUF_EN
                    if (bus.dmemWEN && ib_vld_q && (ib_tag_q == bus.dmemaddr)) begin
                        ib_vld_d = 1'b0;
                    end
`endif
                end else if (bus.imemREN && !bus.halt) begin
                    addr_d  = bus.imemaddr;
                    wr_d    = 1'b0;
                    isd_d   = 1'b0;
                    state_d = IACC;
`ifdef DP_MEM_IBUF_EN
                    if (ib_vld_q && (ib_tag_q == bus.imemaddr)) begin
                        imemload_d = ib_word_q;
                        state_d    = RESP;
                    end
`endif
                end
            end
            DACC, IACC: begin
                // ramready wins over a timeout landing on the same cycle
                if (bus.ramready) begin
                    state_d = RESP;
                    if (!wr_q) begin
                        if (isd_q) dmemload_d = bus.ramload;
                        else       imemload_d = bus.ramload;
                    end
`ifdef DP_MEM_IBUF_EN
                    if (!isd_q) begin
                        ib_vld_d  = 1'b1;
                        ib_tag_d  = addr_q;
                        ib_word_d = bus.ramload;
                    end
`endif
                end else if (tc) begin
                    state_d = RESP;
                    err_d   = 1'b1;
                    if (!wr_q) begin
                        if (isd_q) dmemload_d = ERR_WORD;
                        else       imemload_d = ERR_WORD;
                    end
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            store_q    <= '0;
            wr_q       <= 1'b0;
            isd_q      <= 1'b0;
            imemload_q <= '0;
            dmemload_q <= '0;
            err_q      <= 1'b0;
`ifdef DP_MEM_IBUF_EN
            ib_vld_q   <= 1'b0;
            ib_tag_q   <= '0;
            ib_word_q  <= '0;
`endif
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            store_q    <= store_d;
            wr_q       <= wr_d;
            isd_q      <= isd_d;
            imemload_q <= imemload_d;
            dmemload_q <= dmemload_d;
            err_q      <= err_d;
`ifdef DP_MEM_IBUF_EN
            ib_vld_q   <= ib_vld_d;
            ib_tag_q   <= ib_tag_d;
            ib_word_q  <= ib_word_d;
`endif
        end
    end

    // Strobes decode only registered state, so datapath inputs never reach the RAM directly
    assign bus.ramREN   = (state_q == IACC) || ((state_q == DACC) && !wr_q);
    assign bus.ramWEN   = (state_q == DACC) && wr_q;
    assign bus.ramaddr  = addr_q;
    assign bus.ramstore = store_q;
    assign bus.ihit     = (state_q == RESP) && !isd_q;
    assign bus.dhit     = (state_q == RESP) && isd_q;
    assign bus.imemload = imemload_q;
    assign bus.dmemload = dmemload_q;
    assign bus.err      = err_q;

endmodule

// File: tb/tb_dp_mem_responder.sv
// Directed plus randomized bench for dp_mem_responder against a transaction-level model.
module tb_dp_mem_responder;
    import dp_mem_responder_pkg::*;

    localparam int unsigned TO   = 4;
    localparam word_t       ERRW = 32'hBAD1BAD1;

    logic CLK  = 1'b0;
    logic nRST = 1'b0;
    always #5 CLK = ~CLK;

    dp_mem_responder_if bus();

    dp_mem_responder #(.TIMEOUT(TO), .ERR_WORD(ERRW)) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus.slave)
    );

    int    n_cmp = 0;
    int    n_bad = 0;
    word_t mem [word_t];
    word_t exp_iload = '0;
    word_t exp_dload = '0;
    bit    exp_err   = 1'b0;
    bit    ib_vld    = 1'b0;
    word_t ib_tag    = '0;
    word_t ib_word   = '0;

    function automatic word_t rd(word_t a);
        return mem.exists(a) ? mem[a] : ((a ^ 32'h5A5A_0000) + 32'h1111);
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive_idle();
        bus.imemREN   = 1'b0;
        bus.imemaddr  = '0;
        bus.dmemREN   = 1'b0;
        bus.dmemWEN   = 1'b0;
        bus.dmemaddr  = '0;
        bus.dmemstore = '0;
        bus.halt      = 1'b0;
        bus.ramload   = '0;
        bus.ramready  = 1'b0;
    endtask

    task automatic gap();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    // kind: 0 fetch, 1 data read, 2 data write. lat: strobe cycle that sees ramready (0 = never).
    task automatic phase(input int kind, input word_t a, input word_t st, input int lat,
                         input int extra, input string tag);
        int    n = 0;
        int    cyc = 0;
        int    n_exp;
        bit    done = 1'b0;
        bit    bad_strobe = 1'b0;
        bit    good;
        bit    bufhit = 1'b0;
        logic  ih = 1'b0;
        logic  dh = 1'b0;
`ifdef DP_MEM_IBUF_EN
        bufhit = (kind == 0) && ib_vld && (ib_tag == a);
`endif
        good  = bufhit || (lat >= 1 && lat <= int'(TO));
        n_exp = bufhit ? 0 : (good ? lat : int'(TO));
        while (!done && cyc < int'(TO) + 10) begin
            @(posedge CLK);
            @(negedge CLK);
            cyc++;
            if (bus.ramREN || bus.ramWEN) begin
                n++;
                if (bus.ramaddr !== a || bus.ramWEN !== (kind == 2) || bus.ramREN !== (kind != 2)
                    || (kind == 2 && bus.ramstore !== st)) bad_strobe = 1'b1;
                bus.ramready = (n == lat);
                bus.ramload  = rd(a);
            end else begin
                bus.ramready = 1'b0;
            end
            if (bus.ihit || bus.dhit) begin
                done = 1'b1;
                ih   = bus.ihit;
                dh   = bus.dhit;
                bus.ramready = 1'b0;
                if (kind == 0) bus.imemREN = 1'b0;
                else begin
                    bus.dmemREN = 1'b0;
                    bus.dmemWEN = 1'b0;
                end
            end
        end
        if (kind == 0) begin
            exp_iload = bufhit ? ib_word : (good ? rd(a) : ERRW);
            if (!bufhit && good) begin
                ib_vld  = 1'b1;
                ib_tag  = a;
                ib_word = exp_iload;
            end
        end else if (kind == 1) begin
            exp_dload = good ? rd(a) : ERRW;
        end else begin
            if (good) mem[a] = st;
            if (ib_vld && ib_tag == a) ib_vld = 1'b0;
        end
        if (!good) exp_err = 1'b1;
        chk({tag, " hit_seen"}, 32'(done), 32'd1);
        chk({tag, " latency"}, 32'(cyc), 32'(n_exp + 1 + extra));
        chk({tag, " strobes"}, 32'(n), 32'(n_exp));
        chk({tag, " strobe_sig"}, 32'(bad_strobe), 32'd0);
        chk({tag, " ihit"}, 32'(ih), 32'(kind == 0));
        chk({tag, " dhit"}, 32'(dh), 32'(kind != 0));
        chk({tag, " imemload"}, bus.imemload, exp_iload);
        chk({tag, " dmemload"}, bus.dmemload, exp_dload);
        chk({tag, " err"}, 32'(bus.err), 32'(exp_err));
    endtask

    initial begin
        int quiet_strobes;
        int quiet_hits;
        drive_idle();
        #2;
        chk("rst ramREN", 32'(bus.ramREN), 32'd0);
        chk("rst ramWEN", 32'(bus.ramWEN), 32'd0);
        chk("rst ihit", 32'(bus.ihit), 32'd0);
        chk("rst dhit", 32'(bus.dhit), 32'd0);
        chk("rst ramaddr", bus.ramaddr, 32'd0);
        chk("rst ramstore", bus.ramstore, 32'd0);
        chk("rst imemload", bus.imemload, 32'd0);
        chk("rst dmemload", bus.dmemload, 32'd0);
        chk("rst err", 32'(bus.err), 32'd0);
        @(negedge CLK);
        nRST = 1'b1;
        gap();

        // single fetch, RAM ready on the 2nd strobe cycle
        mem[32'h0] = 32'h3C010001;
        bus.imemREN = 1'b1; bus.imemaddr = 32'h0;
        phase(0, 32'h0, 32'h0, 2, 0, "t1_fetch");
        gap();

        // fetch and load together: data first, fetch after the RESP cycle
        mem[32'h100] = 32'hDEADBEEF;
        bus.imemREN = 1'b1; bus.imemaddr = 32'h4;
        bus.dmemREN = 1'b1; bus.dmemaddr = 32'h100;
        phase(1, 32'h100, 32'h0, 1, 0, "t2_data");
        phase(0, 32'h4, 32'h0, 1, 1, "t2_fetch");
        gap();

        bus.dmemWEN = 1'b1; bus.dmemaddr = 32'h80; bus.dmemstore = 32'h12345678;
        phase(2, 32'h80, 32'h12345678, 1, 0, "t3_write");
        gap();

        bus.dmemREN = 1'b1; bus.dmemaddr = 32'h40;
        phase(1, 32'h40, 32'h0, 0, 0, "t4_timeout");
        gap();
        bus.dmemREN = 1'b1; bus.dmemaddr = 32'h100;
        phase(1, 32'h100, 32'h0, int'(TO), 0, "t4_sticky");
        gap();

        // halted fetch must stay quiet; data still serviced
        bus.halt = 1'b1; bus.imemREN = 1'b1; bus.imemaddr = 32'h4;
        quiet_strobes = 0; quiet_hits = 0;
        for (int i = 0; i < 10; i++) begin
            gap();
            if (bus.ramREN || bus.ramWEN) quiet_strobes++;
            if (bus.ihit || bus.dhit) quiet_hits++;
        end
        chk("t6 halt_strobes", 32'(quiet_strobes), 32'd0);
        chk("t6 halt_hits", 32'(quiet_hits), 32'd0);
        bus.dmemREN = 1'b1; bus.dmemaddr = 32'h100;
        phase(1, 32'h100, 32'h0, 1, 0, "t6_halt_data");
        gap();
        chk("t6 halt_after", 32'(bus.ramREN), 32'd0);
        bus.imemREN = 1'b0; bus.halt = 1'b0;
        gap();
        bus.imemREN = 1'b1; bus.imemaddr = 32'h4;
        phase(0, 32'h4, 32'h0, 1, 0, "t6_refetch");
        gap();

        // reset in the middle of a read
        bus.dmemREN = 1'b1; bus.dmemaddr = 32'h100;
        gap();
        gap();
        gap();
        chk("t5 strobe_before", 32'(bus.ramREN), 32'd1);
        nRST = 1'b0;
        #1;
        chk("t5 ramREN", 32'(bus.ramREN), 32'd0);
        chk("t5 ihit", 32'(bus.ihit), 32'd0);
        chk("t5 dhit", 32'(bus.dhit), 32'd0);
        chk("t5 err", 32'(bus.err), 32'd0);
        chk("t5 dmemload", bus.dmemload, 32'd0);
        drive_idle();
        exp_err = 1'b0; exp_iload = '0; exp_dload = '0; ib_vld = 1'b0;
        @(posedge CLK);
        @(negedge CLK);
        nRST = 1'b1;
        quiet_strobes = 0; quiet_hits = 0;
        for (int i = 0; i < 5; i++) begin
            gap();
            if (bus.ramREN || bus.ramWEN) quiet_strobes++;
            if (bus.ihit || bus.dhit) quiet_hits++;
        end
        chk("t5 post_strobes", 32'(quiet_strobes), 32'd0);
        chk("t5 post_hits", 32'(quiet_hits), 32'd0);

        for (int t = 0; t < 60; t++) begin
            int    r;
            int    dk;
            int    lat;
            int    lat2;
            word_t a;
            word_t a2;
            word_t st;
            r   = int'($urandom_range(0, 3));
            dk  = int'($urandom_range(1, 2));
            a   = word_t'($urandom_range(0, 7)) << 2;
            a2  = word_t'($urandom_range(0, 7)) << 2;
            st  = word_t'($urandom);
            lat = ($urandom_range(0, 7) < 6) ? int'($urandom_range(1, TO)) : int'($urandom_range(0, 1)) * 5;
            lat2 = int'($urandom_range(1, TO + 1));
            if (r == 0) begin
                bus.imemREN = 1'b1; bus.imemaddr = a;
                phase(0, a, '0, lat, 0, "rnd_fetch");
            end else if (r == 3) begin
                bus.imemREN = 1'b1; bus.imemaddr = a2;
                bus.dmemaddr = a; bus.dmemstore = st;
                if (dk == 2) bus.dmemWEN = 1'b1; else bus.dmemREN = 1'b1;
                phase(dk, a, st, lat, 0, "rnd_dual_d");
                phase(0, a2, '0, lat2, 1, "rnd_dual_i");
            end else begin
                bus.dmemaddr = a; bus.dmemstore = st;
                if (r == 2) bus.dmemWEN = 1'b1; else bus.dmemREN = 1'b1;
                phase(r, a, st, lat, 0, r == 2 ? "rnd_write" : "rnd_read");
            end
            gap();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
